// File: rtl/uart_tx_pkg.sv
// Purpose : shared UART types and defaults (line states, FSM encoding, clock/baud defaults).
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Imported by uart_tx and the future uart_rx so both agree on encodings.
package uart_tx_pkg;

    // 2-bit frame state encoding shared by TX and RX.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b10,
        ST_STOP  = 2'b11
    } uart_state_e;

    // Default system clock and line rate.
    localparam int UART_DEF_CLK_FREQ  = 50_000_000;
    localparam int UART_DEF_BAUD_RATE = 9600;

    // Line levels.
    localparam logic UART_LVL_IDLE  = 1'b1;
    localparam logic UART_LVL_START = 1'b0;
    localparam logic UART_LVL_STOP  = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// Purpose : byte handshake between the debug controller and the UART transmitter.
// Latency : n/a (wires only).
// Backpressure: producer holds tx_start until tx_done pulses, then drops it for >= 1 cycle.
// Signals : tx_start (req, level), tx_data (byte, sampled on accept),
//           tx_done (1-cycle completion pulse), tx_busy (frame on the line).
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);

    logic                 tx_start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_done;
    logic                 tx_busy;

    // Producer side (debug controller).
    modport master (
        output tx_start,
        output tx_data,
        input  tx_done,
        input  tx_busy
    );

    // Transmitter side.
    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_done,
        output tx_busy
    );

endinterface

// File: rtl/uart_baud_gen.sv
// Purpose : bit-period timer; o_tick marks the last clock of every serial bit.
// Latency : first tick CLKS_PER_BIT cycles after i_clear (clear cycle not counted).
// Backpressure: none; free-running, restarted by i_clear.
// Ports   : i_clk, i_reset (sync, active-high), i_clear (restart count), o_tick.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count 0..CLKS_PER_BIT-1 and wrap explicitly, since the period need
    // not be a power of two.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_clear || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Decoded from the registered count; the FSM only consumes it outside IDLE,
    // where i_clear cannot be active, so no gating with i_clear is needed.
    assign o_tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx.sv
// Purpose : 8N1-style serial transmitter: start bit, DATA_BITS LSB-first, stop bit.
// Latency : line falls 1 cycle after accept; tx_done pulses (DATA_BITS+2)*CLKS_PER_BIT+1 cycles after accept.
// Backpressure: one byte per request; a request must drop for >= 1 idle cycle before the next is accepted.
// Ports   : i_clk, i_reset (sync, active-high), tx_bus (slave handshake: start/data in,
//           done/busy out), o_tx (serial line, idle high). All outputs registered.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLK_FREQ     = UART_DEF_CLK_FREQ,
    parameter int BAUD_RATE    = UART_DEF_BAUD_RATE,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
    input  logic       i_clk,
    input  logic       i_reset,
    uart_tx_if.slave   tx_bus,
    output logic       o_tx
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    uart_state_e          state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_nxt;
    logic [IDX_W-1:0]     idx_q;
    logic                 tx_q;
    logic                 done_q;
    logic                 busy_q;
    logic                 armed_q;

    logic                 accept;
    logic                 bit_tick;

    // armed_q drops when a frame completes and only comes back after an idle
    // cycle with the request low, so a level-held request sends exactly once.
    assign accept    = (state_q == ST_IDLE) && tx_bus.tx_start && armed_q;
    assign shift_nxt = shift_q >> 1;

    // Restarting the timer on accept aligns bit boundaries to the accept edge.
    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (accept),
        .o_tick  (bit_tick)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= UART_LVL_IDLE;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            armed_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        shift_q <= tx_bus.tx_data;
                        idx_q   <= '0;
                        tx_q    <= UART_LVL_START;
                        busy_q  <= 1'b1;
                        state_q <= ST_START;
                    end else if (!tx_bus.tx_start) begin
                        armed_q <= 1'b1;
                    end
                end

                ST_START: begin
                    if (bit_tick) begin
                        tx_q    <= shift_q[0];
                        state_q <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (bit_tick) begin
                        shift_q <= shift_nxt;
                        // Index wraps after the last bit; it is reloaded on the next accept.
                        idx_q   <= idx_q + IDX_W'(1);
                        if (idx_q == IDX_LAST) begin
                            tx_q    <= UART_LVL_STOP;
                            state_q <= ST_STOP;
                        end else begin
                            tx_q    <= shift_nxt[0];
                        end
                    end
                end

                ST_STOP: begin
                    if (bit_tick) begin
                        tx_q    <= UART_LVL_IDLE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        armed_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_tx           = tx_q;
    assign tx_bus.tx_done = done_q;
    assign tx_bus.tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Purpose : scoreboard bench for uart_tx with CLKS_PER_BIT=4, DATA_BITS=8.
// Latency : n/a.
// Backpressure: n/a.
module tb_uart_tx;

    localparam int CPB       = 4;
    localparam int DB        = 8;
    localparam int FRAME_CYC = (DB + 2) * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;

    uart_tx_if #(.DATA_BITS(DB)) bus();

    uart_tx #(
        .DATA_BITS    (DB),
        .CLK_FREQ     (40),
        .BAUD_RATE    (10),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .tx_bus  (bus),
        .o_tx    (tx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected 40-sample line for one frame; bit 0 is the first start-bit cycle.
    function automatic logic [FRAME_CYC-1:0] expected_line(input logic [7:0] b);
        logic [FRAME_CYC-1:0] v;
        logic [7:0]           bb;
        logic                 lvl;
        v  = '0;
        bb = b;
        for (int s = 0; s < DB + 2; s++) begin
            if (s == 0) begin
                lvl = 1'b0;
            end else if (s == DB + 1) begin
                lvl = 1'b1;
            end else begin
                lvl = bb[0];
                bb  = bb >> 1;
            end
            v = {{CPB{lvl}}, v[FRAME_CYC-1:CPB]};
        end
        return v;
    endfunction

    // Mid-bit decode of the data bits from a captured line.
    function automatic logic [7:0] decode_line(input logic [FRAME_CYC-1:0] l);
        logic [FRAME_CYC-1:0] t;
        logic [7:0]           d;
        d = '0;
        t = l >> (CPB + 2);
        for (int k = 0; k < DB; k++) begin
            d = {t[0], d[7:1]};
            t = t >> CPB;
        end
        return d;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [7:0]           exp_q[$];
    logic [7:0]           cur_exp;
    logic [FRAME_CYC-1:0] line_s;
    int  pos        = 0;
    bit  in_frame   = 1'b0;
    bit  done_due   = 1'b0;
    bit  busy_ok    = 1'b0;
    int  nframes    = 0;
    int  ndone      = 0;
    int  last_start = 0;
    int  last_end   = 0;
    int  last_gap   = 0;

    always @(negedge clk) begin
        if (rst) begin
            in_frame = 1'b0;
            done_due = 1'b0;
        end else begin
            if (done_due) begin
                done_due = 1'b0;
                chk("done_slot", longint'({bus.tx_done, bus.tx_busy}), 2);
                if (bus.tx_done) ndone++;
            end else if (bus.tx_done) begin
                ndone++;
                chk("stray_done", longint'(bus.tx_done), 0);
            end

            if (in_frame) begin
                line_s = {tx, line_s[FRAME_CYC-1:1]};
                if (bus.tx_busy !== 1'b1) busy_ok = 1'b0;
                pos++;
                if (pos == FRAME_CYC) begin
                    in_frame = 1'b0;
                    done_due = 1'b1;
                    last_end = cyc;
                    nframes++;
                    chk("frame_byte", longint'(decode_line(line_s)), longint'(cur_exp));
                    chk("frame_line", longint'(line_s), longint'(expected_line(cur_exp)));
                    chk("frame_busy", longint'(busy_ok), 1);
                end
            end else if (tx === 1'b0) begin
                in_frame   = 1'b1;
                pos        = 1;
                line_s     = '0;
                busy_ok    = (bus.tx_busy === 1'b1);
                last_start = cyc;
                last_gap   = cyc - last_end - 1;
                chk("sb_has_expected", longint'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) cur_exp = exp_q.pop_front();
                else                   cur_exp = 8'h00;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input string name, output int dc);
        dc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.tx_done === 1'b1) begin
                dc = cyc;
                break;
            end
        end
        chk(name, longint'(dc >= 0), 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         c0;
        int         dc;
        int         n0f;
        int         n0d;
        logic [31:0] word;
        logic [7:0]  b;

        bus.tx_start = 1'b0;
        bus.tx_data  = '0;
        rst          = 1'b1;
        step(3);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_tx",   longint'(tx), 1);
        chk("reset_done", longint'(bus.tx_done), 0);
        chk("reset_busy", longint'(bus.tx_busy), 0);

        // Single byte with exact cycle timing.
        step(1);
        c0 = cyc;
        exp_q.push_back(8'hA5);
        bus.tx_data  = 8'hA5;
        bus.tx_start = 1'b1;
        wait_done("a5_done_seen", dc);
        bus.tx_start = 1'b0;
        chk("a5_done_cycle",  longint'(dc - c0), 41);
        chk("a5_start_cycle", longint'(last_start - c0), 1);

        // Held request: one frame only, then a 1-cycle drop re-arms.
        step(2);
        n0f = nframes;
        n0d = ndone;
        exp_q.push_back(8'h3C);
        bus.tx_data  = 8'h3C;
        bus.tx_start = 1'b1;
        step(60);
        chk("held_frames", longint'(nframes - n0f), 1);
        chk("held_dones",  longint'(ndone - n0d), 1);
        bus.tx_start = 1'b0;
        step(1);
        exp_q.push_back(8'h3C);
        bus.tx_start = 1'b1;
        wait_done("held2_done_seen", dc);
        bus.tx_start = 1'b0;
        chk("held_rearm_frames", longint'(nframes - n0f), 2);

        // Debug handshake: 0xDEADBEEF as four back-to-back bytes, MSB first.
        step(2);
        word = 32'hDEADBEEF;
        n0d  = ndone;
        for (int i = 0; i < 4; i++) begin
            b = word[31:24];
            word = word << 8;
            exp_q.push_back(b);
            bus.tx_data  = b;
            bus.tx_start = 1'b1;
            wait_done("hs_done_seen", dc);
            if (i > 0) chk("hs_gap", longint'(last_gap), 3);
            step(1);
            bus.tx_start = 1'b0;
            step(1);
        end
        chk("hs_dones", longint'(ndone - n0d), 4);

        // Data change mid-frame has no effect.
        step(2);
        exp_q.push_back(8'h0F);
        bus.tx_data  = 8'h0F;
        bus.tx_start = 1'b1;
        step(10);
        bus.tx_data  = 8'hF0;
        wait_done("dchg_done_seen", dc);
        bus.tx_start = 1'b0;

        // Reset mid-frame: abort, no done, then a clean frame.
        step(2);
        exp_q.push_back(8'h00);
        bus.tx_data  = 8'h00;
        bus.tx_start = 1'b1;
        step(20);
        rst          = 1'b1;
        bus.tx_start = 1'b0;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_abort_tx",   longint'(tx), 1);
        chk("rst_abort_busy", longint'(bus.tx_busy), 0);
        n0d = ndone;
        step(60);
        chk("rst_no_done", longint'(ndone - n0d), 0);
        exp_q.push_back(8'h96);
        bus.tx_data  = 8'h96;
        bus.tx_start = 1'b1;
        wait_done("rst_after_done_seen", dc);
        bus.tx_start = 1'b0;

        // Request pulsed while busy is ignored.
        step(2);
        n0f = nframes;
        exp_q.push_back(8'h81);
        bus.tx_data  = 8'h81;
        bus.tx_start = 1'b1;
        step(1);
        bus.tx_start = 1'b0;
        step(4);
        bus.tx_data  = 8'h55;
        bus.tx_start = 1'b1;
        step(4);
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;
        wait_done("busy_done_seen", dc);
        step(50);
        chk("busy_frames", longint'(nframes - n0f), 1);

        chk("sb_drain", longint'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
